layer3_weight_sched: RTL and testbench

LAYER3_WEIGHT_SCHED -- requirements
Module: layer3_weight_sched

---
 rtl/cnn_sched_pkg.sv | 13 +
 rtl/cnn_weight_cnt.sv | 28 ++
 rtl/layer3_weight_sched.sv | 123 ++++++++++++
 tb/tb_layer3_weight_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared scheduler definitions: FSM state encoding and word-counter width.
package cnn_sched_pkg;

  localparam int unsigned CNT_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD1 = 2'd1,
    LOAD2 = 2'd2,
    LOAD3 = 2'd3
  } state_t;

endpackage

// File: rtl/cnn_weight_cnt.sv
// Word counter with synchronous clear, increment and a last-word flag
// raised when the count equals the supplied limit.
module cnn_weight_cnt
  import cnn_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign last_o = (count_q == limit_i);

endmodule

// File: rtl/layer3_weight_sched.sv
// Streams weight words into conv1, conv2 and downsample-conv in sequence.
// Optional sticky protocol-error flag: define LAYER3_WEIGHT_SCHED_ERR_EN.
module layer3_weight_sched
  import cnn_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int W1_NUM     = 32768,
  parameter int W2_NUM     = 589824,
  parameter int W3_NUM     = 32768
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic                  ready_out,
  output logic                  valid_weight_out1,
  output logic                  valid_weight_out2,
  output logic                  valid_weight_out3,
  output logic [DATA_WIDTH-1:0] weight_out1,
  output logic [DATA_WIDTH-1:0] weight_out2,
  output logic [DATA_WIDTH-1:0] weight_out3,
  output logic                  busy,
  output logic                  done
`ifdef LAYER3_WEIGHT_SCHED_ERR_EN
  , output logic                err
`endif
);

  state_t                state_q;
  logic                  v1_q, v2_q, v3_q, done_q;
  logic [DATA_WIDTH-1:0] w1_q, w2_q, w3_q;
  logic [CNT_W-1:0]      limit;
  logic                  xfer, last, cnt_clr;

  assign ready_out = (state_q != IDLE);
  assign xfer      = valid_in && ready_out;
  assign cnt_clr   = (xfer && last) || (state_q == IDLE && start);

  always_comb begin
    limit = '0;
    case (state_q)
      LOAD1:   limit = CNT_W'(W1_NUM - 1);
      LOAD2:   limit = CNT_W'(W2_NUM - 1);
      LOAD3:   limit = CNT_W'(W3_NUM - 1);
      default: limit = '0;
    endcase
  end

  cnn_weight_cnt u_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (cnt_clr),
    .inc_i   (xfer),
    .limit_i (limit),
    .last_o  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      done_q  <= 1'b0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
    end else begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) state_q <= LOAD1;
        LOAD1: if (xfer) begin
          w1_q <= weight_in;
          v1_q <= 1'b1;
          if (last) state_q <= LOAD2;
        end
        LOAD2: if (xfer) begin
          w2_q <= weight_in;
          v2_q <= 1'b1;
          if (last) state_q <= LOAD3;
        end
        LOAD3: if (xfer) begin
          w3_q <= weight_in;
          v3_q <= 1'b1;
          if (last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // busy stays up through the done cycle so it falls one cycle after done
  assign busy              = (state_q != IDLE) || done_q;
  assign done              = done_q;
  assign valid_weight_out1 = v1_q;
  assign valid_weight_out2 = v2_q;
  assign valid_weight_out3 = v3_q;
  assign weight_out1       = w1_q;
  assign weight_out2       = w2_q;
  assign weight_out3       = w3_q;

`ifdef LAYER3_WEIGHT_SCHED_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((state_q == IDLE && valid_in) || (state_q != IDLE && start)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_layer3_weight_sched.sv
// Directed scoreboard bench for layer3_weight_sched with W1/W2/W3 = 4/9/2.
module tb_layer3_weight_sched;

  localparam int DW = 32;
  localparam int W1 = 4;
  localparam int W2 = 9;
  localparam int W3 = 2;
  localparam int WT = W1 + W2 + W3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] weight_in = '0;
  logic          ready_out, busy, done;
  logic          vo1, vo2, vo3;
  logic [DW-1:0] wo1, wo2, wo3;
`ifdef LAYER3_WEIGHT_SCHED_ERR_EN
  logic          err;
`endif

  layer3_weight_sched #(
    .DATA_WIDTH (DW),
    .W1_NUM     (W1),
    .W2_NUM     (W2),
    .W3_NUM     (W3)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .valid_in          (valid_in),
    .weight_in         (weight_in),
    .ready_out         (ready_out),
    .valid_weight_out1 (vo1),
    .valid_weight_out2 (vo2),
    .valid_weight_out3 (vo3),
    .weight_out1       (wo1),
    .weight_out2       (wo2),
    .weight_out3       (wo3),
    .busy              (busy),
    .done              (done)
`ifdef LAYER3_WEIGHT_SCHED_ERR_EN
    , .err             (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          conv;
    logic [DW-1:0] data;
    bit          last;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  bit            in_seq = 1'b0;
  int            widx = 0;
  logic [DW-1:0] last_w [1:3];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    in_seq = 1'b0;
    widx   = 0;
    for (int unsigned i = 1; i <= 3; i++) last_w[i] = '0;
  endtask

  // Drive one cycle of inputs, then check every output #1 after the edge.
  task automatic step(input bit v, input logic [DW-1:0] d);
    bit    s;
    bit    pushed;
    bit    ends;
    exp_t  e;
    logic [2:0] vexp;
    s         = start;
    pushed    = 1'b0;
    ends      = 1'b0;
    valid_in  = v;
    weight_in = d;
    if (v && in_seq) begin
      e.conv = (widx < W1) ? 1 : (widx < W1 + W2) ? 2 : 3;
      e.data = d;
      e.last = (widx == WT - 1);
      sb.push_back(e);
      pushed = 1'b1;
      widx++;
      if (e.last) in_seq = 1'b0;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    valid_in = 1'b0;
    if (s && !in_seq && !pushed) begin
      in_seq = 1'b1;
      widx   = 0;
    end
    vexp = 3'b000;
    if (pushed) begin
      e = sb.pop_front();
      vexp = 3'b001 << (e.conv - 1);
      last_w[e.conv] = e.data;
      ends = e.last;
    end
    chk("valid_vec", {29'd0, vo3, vo2, vo1}, {29'd0, vexp});
    chk("weight_out1", wo1, last_w[1]);
    chk("weight_out2", wo2, last_w[2]);
    chk("weight_out3", wo3, last_w[3]);
    chk("done", {31'd0, done}, {31'd0, ends});
    chk("ready_out", {31'd0, ready_out}, {31'd0, in_seq});
    chk("busy", {31'd0, busy}, {31'd0, (in_seq || ends)});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, ready_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_valids"}, {29'd0, vo3, vo2, vo1}, 32'd0);
    chk({tag, "_w1"}, wo1, 32'd0);
    chk({tag, "_w2"}, wo2, 32'd0);
    chk({tag, "_w3"}, wo3, 32'd0);
  endtask

  initial begin
    clear_model();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Continuous stream; start cycle also carries a word that must not transfer
    start = 1'b1;
    step(1'b1, 32'h100);
    for (int i = 0; i < WT; i++) step(1'b1, 32'(i + 32'h10));
    step(1'b0, 32'h0);
    chk("sb_empty_1", 32'(sb.size()), 32'd0);

    // Alternating valid with data 0,1,2,...
    start = 1'b1;
    step(1'b0, 32'h0);
    for (int i = 0; i < WT; i++) begin
      step(1'b1, 32'(i));
      step(1'b0, 32'hDEAD_BEEF);
    end
    chk("tog_w1", wo1, 32'd3);
    chk("tog_w2", wo2, 32'd12);
    chk("tog_w3", wo3, 32'd14);

    // Asynchronous reset after the 6th word, then a clean reload
    start = 1'b1;
    step(1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i + 32'h40));
    #2;
    reset = 1'b0;
    #1;
    clear_model();
    chk_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    step(1'b0, 32'h0);
    for (int i = 0; i < WT; i++) step(1'b1, 32'(i + 32'h50));
    chk("reload_first_w1", wo1, 32'h53);
    step(1'b0, 32'h0);

`ifdef LAYER3_WEIGHT_SCHED_ERR_EN
    chk("err_clean", {31'd0, err}, 32'd0);
`endif

    // start pulsed during LOAD2 must not disturb the sequence
    start = 1'b1;
    step(1'b0, 32'h0);
    for (int i = 0; i < WT; i++) begin
      if (i == 6) start = 1'b1;
      step(1'b1, 32'(i + 32'h70));
    end
    step(1'b0, 32'h0);
`ifdef LAYER3_WEIGHT_SCHED_ERR_EN
    chk("err_set", {31'd0, err}, 32'd1);
    step(1'b0, 32'h0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("err_reset", {31'd0, err}, 32'd0);
    clear_model();
    @(negedge clk);
    reset = 1'b1;
`endif

    // valid_in held high in IDLE for 5 cycles is ignored
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i + 32'hA0));
    start = 1'b1;
    step(1'b0, 32'h0);
    for (int i = 0; i < WT; i++) step(1'b1, 32'(i + 32'hC0));
    step(1'b0, 32'h0);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
